// File: rtl/alu_regfile_flags_pkg.sv
// Shared constants, flag command encodings and helpers for the ALU operand/write-back stage.
package alu_regfile_flags_pkg;

    localparam int DATA_W  = 8;
    localparam int REG_CNT = 8;
    localparam int ADDR_W  = 3;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        FLAG_HOLD = 2'b00,
        FLAG_LOAD = 2'b01,
        FLAG_CLRC = 2'b10,
        FLAG_SETC = 2'b11
    } flagOp_e;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alu_regfile_flags_if.sv
// Operand/write-back bus between the CPU datapath (master) and the register/flag stage (slave).
interface alu_regfile_flags_if;
    import alu_regfile_flags_pkg::*;

    logic [ADDR_W-1:0] rdAddr1;
    logic [ADDR_W-1:0] rdAddr2;
    logic [DATA_W-1:0] rdData1;
    logic [DATA_W-1:0] rdData2;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic [1:0]        flagOp;
    logic              aluCOut;
    logic              aluZero;
    logic              cFlag;
    logic              zFlag;
    logic [CNT_W-1:0]  wrCount;

    modport master (
        output rdAddr1, rdAddr2, wrEn, wrAddr, wrData, flagOp, aluCOut, aluZero,
        input  rdData1, rdData2, cFlag, zFlag, wrCount
    );

    modport slave (
        input  rdAddr1, rdAddr2, wrEn, wrAddr, wrData, flagOp, aluCOut, aluZero,
        output rdData1, rdData2, cFlag, zFlag, wrCount
    );
endinterface

// File: rtl/alu_regfile_flags_flag_reg.sv
// Carry/zero flag register; stored carry feeds back as ALU carry-in.
module flag_reg
    import alu_regfile_flags_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] flagOp,
    input  logic       aluCOut,
    input  logic       aluZero,
    output logic       cFlag,
    output logic       zFlag
);

    logic cNext;
    logic zNext;

    // Any unrecognised (including undefined) command falls through to hold.
    always_comb begin
        cNext = cFlag;
        zNext = zFlag;
        case (flagOp_e'(flagOp))
            FLAG_LOAD: begin
                cNext = aluCOut;
                zNext = aluZero;
            end
            FLAG_CLRC: cNext = 1'b0;
            FLAG_SETC: cNext = 1'b1;
            FLAG_HOLD: ;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cFlag <= 1'b0;
            zFlag <= 1'b0;
        end else begin
            cFlag <= cNext;
            zFlag <= zNext;
        end
    end

endmodule

// File: rtl/alu_regfile_flags.sv
// Register file, write counter and flag register wrapped around the CPU's 8-bit ALU.
module alu_regfile_flags
    import alu_regfile_flags_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_regfile_flags_if.slave bus
);

    logic [REG_CNT-1:0][DATA_W-1:0] regFile;
    logic [CNT_W-1:0]               wrCount;

    genvar gi;
    generate
        for (gi = 0; gi < REG_CNT; gi++) begin : gReg
            logic [DATA_W-1:0] q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (bus.wrEn && (bus.wrAddr == ADDR_W'(gi))) begin
                    q <= bus.wrData;
                end
            end

            assign regFile[gi] = q;
        end
    endgenerate

    // Reads come straight from stored state: no bypass, so ALU out cannot loop back combinationally.
    assign bus.rdData1 = regFile[bus.rdAddr1];
    assign bus.rdData2 = regFile[bus.rdAddr2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrCount <= '0;
        end else if (bus.wrEn) begin
            wrCount <= satInc(wrCount);
        end
    end

    assign bus.wrCount = wrCount;

    flag_reg uFlagReg (
        .clk     (clk),
        .rst     (rst),
        .flagOp  (bus.flagOp),
        .aluCOut (bus.aluCOut),
        .aluZero (bus.aluZero),
        .cFlag   (bus.cFlag),
        .zFlag   (bus.zFlag)
    );

endmodule

// File: tb/tb_alu_regfile_flags.sv
// Directed bench for alu_regfile_flags with a queue scoreboard of expected values.
module tb_alu_regfile_flags;
    import alu_regfile_flags_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_regfile_flags_if bus ();

    alu_regfile_flags dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    string      tagQ[$];
    logic [7:0] expQ[$];

    logic [7:0] mdl [REG_CNT];
    int         expCnt;

    task automatic expect_val(input string tag, input logic [7:0] v);
        tagQ.push_back(tag);
        expQ.push_back(v);
    endtask

    task automatic check_val(input logic [7:0] obs);
        string      tag;
        logic [7:0] exp;
        tag = tagQ.pop_front();
        exp = expQ.pop_front();
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic c, input logic z);
        expect_val({tag, "_c"}, {7'd0, c});
        expect_val({tag, "_z"}, {7'd0, z});
        check_val({7'd0, bus.cFlag});
        check_val({7'd0, bus.zFlag});
    endtask

    task automatic chk_all_regs(input string tag);
        for (int a = 0; a < REG_CNT; a++) begin
            bus.rdAddr1 = ADDR_W'(a);
            bus.rdAddr2 = ADDR_W'(REG_CNT - 1 - a);
            #1;
            expect_val($sformatf("%s_r1_%0d", tag, a), mdl[a]);
            expect_val($sformatf("%s_r2_%0d", tag, REG_CNT - 1 - a), mdl[REG_CNT - 1 - a]);
            check_val(bus.rdData1);
            check_val(bus.rdData2);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        bus.wrEn   = 1'b1;
        bus.wrAddr = a;
        bus.wrData = d;
        tick();
        mdl[a] = d;
        expCnt = (expCnt < 255) ? expCnt + 1 : 255;
        bus.wrEn = 1'b0;
    endtask

    initial begin
        bus.rdAddr1 = '0;
        bus.rdAddr2 = '0;
        bus.wrEn    = 1'b0;
        bus.wrAddr  = '0;
        bus.wrData  = '0;
        bus.flagOp  = FLAG_HOLD;
        bus.aluCOut = 1'b0;
        bus.aluZero = 1'b0;
        for (int a = 0; a < REG_CNT; a++) mdl[a] = 8'h00;
        expCnt = 0;

        // Reset asserted between edges from time zero
        #2;
        chk_all_regs("reset");
        chk_flags("reset", 1'b0, 1'b0);
        expect_val("reset_cnt", 8'd0);
        check_val(bus.wrCount);
        tick();
        rst = 1'b0;
        tick();

        // Write R3 then read it on both ports
        do_write(3'd3, 8'hA5);
        bus.rdAddr1 = 3'd3;
        bus.rdAddr2 = 3'd3;
        #1;
        expect_val("wr_r1", 8'hA5);
        expect_val("wr_r2", 8'hA5);
        expect_val("wr_cnt", 8'(expCnt));
        check_val(bus.rdData1);
        check_val(bus.rdData2);
        check_val(bus.wrCount);

        // Same-cycle read of the write target returns the old value
        do_write(3'd2, 8'h10);
        bus.wrEn    = 1'b1;
        bus.wrAddr  = 3'd2;
        bus.wrData  = 8'h22;
        bus.rdAddr1 = 3'd2;
        bus.rdAddr2 = 3'd3;
        #1;
        expect_val("rw_before", 8'h10);
        expect_val("rw_other", 8'hA5);
        check_val(bus.rdData1);
        check_val(bus.rdData2);
        tick();
        bus.wrEn = 1'b0;
        mdl[2] = 8'h22;
        expCnt++;
        expect_val("rw_after", 8'h22);
        expect_val("rw_cnt", 8'(expCnt));
        check_val(bus.rdData1);
        check_val(bus.wrCount);

        // wrEn=0 leaves everything alone
        bus.wrAddr = 3'd3;
        bus.wrData = 8'hEE;
        tick();
        chk_all_regs("noen");
        expect_val("noen_cnt", 8'(expCnt));
        check_val(bus.wrCount);

        // Flag load then hold while ALU carry drops
        bus.aluCOut = 1'b1;
        bus.aluZero = 1'b0;
        bus.flagOp  = FLAG_LOAD;
        tick();
        chk_flags("load1", 1'b1, 1'b0);
        bus.flagOp  = FLAG_HOLD;
        bus.aluCOut = 1'b0;
        bus.aluZero = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk_flags("hold3", 1'b1, 1'b0);

        // Load zero, then clear/set carry leave zero untouched
        bus.flagOp = FLAG_LOAD;
        tick();
        chk_flags("loadz", 1'b0, 1'b1);
        bus.flagOp  = FLAG_SETC;
        bus.aluZero = 1'b0;
        tick();
        chk_flags("setc0", 1'b1, 1'b1);
        bus.flagOp = FLAG_CLRC;
        tick();
        chk_flags("clrc", 1'b0, 1'b1);
        bus.flagOp = FLAG_SETC;
        tick();
        chk_flags("setc", 1'b1, 1'b1);

        // Register write and flag load in the same cycle
        bus.flagOp  = FLAG_LOAD;
        bus.aluCOut = 1'b0;
        bus.aluZero = 1'b0;
        do_write(3'd0, 8'h5A);
        bus.flagOp = FLAG_HOLD;
        chk_flags("both", 1'b0, 1'b0);
        chk_all_regs("both");

        // 300 back-to-back writes saturate the counter
        bus.flagOp = FLAG_SETC;
        bus.wrEn   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.wrAddr = 3'(i);
            bus.wrData = 8'(i * 7 + 1);
            tick();
            mdl[i % REG_CNT] = 8'(i * 7 + 1);
            expCnt = (expCnt < 255) ? expCnt + 1 : 255;
        end
        bus.flagOp = FLAG_HOLD;
        expect_val("sat_cnt", 8'(expCnt));
        check_val(bus.wrCount);
        chk_all_regs("sat");
        chk_flags("sat", 1'b1, 1'b0);

        // Reset mid-cycle with a write pending: immediate clear, nothing lands
        bus.wrEn   = 1'b1;
        bus.wrAddr = 3'd7;
        bus.wrData = 8'hFF;
        #2;
        rst = 1'b1;
        #1;
        for (int a = 0; a < REG_CNT; a++) mdl[a] = 8'h00;
        expCnt = 0;
        expect_val("rst_cnt", 8'd0);
        check_val(bus.wrCount);
        chk_all_regs("rst_now");
        chk_flags("rst_now", 1'b0, 1'b0);
        bus.flagOp = FLAG_SETC;
        tick();
        tick();
        chk_all_regs("rst_held");
        chk_flags("rst_held", 1'b0, 1'b0);
        expect_val("rst_held_cnt", 8'd0);
        check_val(bus.wrCount);
        bus.wrEn   = 1'b0;
        bus.flagOp = FLAG_HOLD;
        rst = 1'b0;
        tick();
        chk_all_regs("post_rst");
        expect_val("post_rst_cnt", 8'd0);
        check_val(bus.wrCount);

        if (tagQ.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d required=0", tagQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
